// File: rtl/sm83_dbg_uart.sv
// sm83_dbg_uart: 8N1 UART bridge in front of the SM83 debug interface.
// RX bytes are buffered and presented on a toggle (seq/ack) handshake; TX bytes
// are taken from a toggle handshake and serialised LSB first.
// Optional build macro SM83_DBG_UART_RXFIFO_EN: 4-entry RX FIFO instead of a
// single holding register.
module sm83_dbg_uart #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] data_rx,
    output logic       data_rx_valid,
    output logic       data_rx_seq,
    input  logic       data_rx_ack,
    input  logic [7:0] data_tx,
    input  logic       data_tx_seq,
    output logic       data_tx_ack,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef SM83_DBG_UART_RXFIFO_EN
    localparam int unsigned Depth = 4;
`else
    localparam int unsigned Depth = 1;
`endif

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWaitHigh} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    // ------------------------------------------------------------------
    // RX synchroniser
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       rx_s;

    // Two-flop synchroniser for the asynchronous serial input, idles high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd};
        end
    end

    assign rx_s = sync_q[1];

    // ------------------------------------------------------------------
    // RX framer
    // ------------------------------------------------------------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_done;
    logic        rx_ferr;

    // RX framer state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state: mid-bit sampling, glitch rejection and stop-bit check.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                if (!rx_s) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    rx_state_d = rx_s ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d = '0;
                    if (rx_s) begin
                        rx_done    = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_ferr    = 1'b1;
                        rx_state_d = RxWaitHigh;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxWaitHigh: begin
                if (rx_s) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // RX buffer and presentation
    // ------------------------------------------------------------------
    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            buf_full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [7:0]      data_rx_q;
    logic            rx_seq_q;
    logic            frame_err_q;
    logic            overrun_q;

    assign data_rx_valid = rx_seq_q ^ data_rx_ack;
    assign buf_full      = (count_q == CntFull);
    assign pop           = !data_rx_valid && (count_q != '0);
    // A pop in the same cycle frees a slot for the incoming byte.
    assign push          = rx_done && (!buf_full || pop);
    assign drop          = rx_done && buf_full && !pop;

    // Buffer storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_shift_q;
        end
    end

    // Buffer pointers, occupancy, presented byte and status pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_rx_q   <= 8'h00;
            rx_seq_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
                data_rx_q <= mem_q[rd_ptr_q];
                rx_seq_q  <= ~rx_seq_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            frame_err_q <= rx_ferr;
            overrun_q   <= drop;
        end
    end

    assign data_rx     = data_rx_q;
    assign data_rx_seq = rx_seq_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

    // ------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_ack_q, tx_ack_d;

    // TX state register; txd is registered so it is glitch-free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_ack_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_ack_q   <= tx_ack_d;
        end
    end

    // TX next state: accept a request only in idle, then emit start/data/stop.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_ack_d   = tx_ack_q;
        case (tx_state_q)
            TxIdle: begin
                txd_d = 1'b1;
                if (data_tx_seq != tx_ack_q) begin
                    tx_shift_d = data_tx;
                    tx_ack_d   = data_tx_seq;
                    tx_state_d = TxStart;
                    tx_cnt_d   = '0;
                    txd_d      = 1'b0;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxData: begin
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TxStop;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TxStop: begin
                txd_d = 1'b1;
                if (tx_cnt_q == BitLast) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    assign txd         = txd_q;
    assign data_tx_ack = tx_ack_q;

endmodule

// File: tb/tb_sm83_dbg_uart.sv
// Directed bench for sm83_dbg_uart at CLKS_PER_BIT=16.
module tb_sm83_dbg_uart;

    localparam int unsigned Cpb = 16;
`ifdef SM83_DBG_UART_RXFIFO_EN
    localparam int Retain = 5;
`else
    localparam int Retain = 2;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       txd;
    logic [7:0] data_rx;
    logic       data_rx_valid;
    logic       data_rx_seq;
    logic       data_rx_ack = 1'b0;
    logic [7:0] data_tx = 8'h00;
    logic       data_tx_seq = 1'b0;
    logic       data_tx_ack;
    logic       frame_err;
    logic       overrun;

    int nvec = 0;
    int nerr = 0;
    int tog_idx;
    int fe_cnt;
    int ov_cnt;

    sm83_dbg_uart #(.CLKS_PER_BIT(Cpb)) dut (
        .clk           (clk),
        .reset         (reset),
        .rxd           (rxd),
        .txd           (txd),
        .data_rx       (data_rx),
        .data_rx_valid (data_rx_valid),
        .data_rx_seq   (data_rx_seq),
        .data_rx_ack   (data_rx_ack),
        .data_tx       (data_tx),
        .data_tx_seq   (data_tx_seq),
        .data_tx_ack   (data_tx_ack),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Drive one 8N1 frame starting at the current negedge; records the frame-relative
    // cycle of the first data_rx_seq change and counts frame_err/overrun pulses.
    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        logic       seq0;
        frame   = {stop_bit, b, 1'b0};
        seq0    = data_rx_seq;
        tog_idx = 0;
        fe_cnt  = 0;
        ov_cnt  = 0;
        for (int i = 0; i < 10; i++) begin
            rxd = frame[i];
            for (int k = 0; k < int'(Cpb); k++) begin
                @(negedge clk);
                if (data_rx_seq !== seq0 && tog_idx == 0) tog_idx = i * int'(Cpb) + k + 1;
                if (frame_err === 1'b1) fe_cnt++;
                if (overrun === 1'b1) ov_cnt++;
            end
        end
        rxd = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if (txd !== 1'b1) begin
            nerr++; $display("FAIL reset_txd: got %b want 1", txd);
        end
        nvec++;
        if (data_rx !== 8'h00) begin
            nerr++; $display("FAIL reset_data_rx: got %h want 00", data_rx);
        end
        nvec++;
        if ({data_rx_seq, data_rx_valid, data_tx_ack} !== 3'b000) begin
            nerr++; $display("FAIL reset_handshake: got %b want 000",
                             {data_rx_seq, data_rx_valid, data_tx_ack});
        end
        nvec++;
        if ({frame_err, overrun} !== 2'b00) begin
            nerr++; $display("FAIL reset_pulses: got %b want 00", {frame_err, overrun});
        end
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_rx_basic();
        uart_send(8'hA5, 1'b1);
        nvec++;
        if (data_rx !== 8'hA5) begin
            nerr++; $display("FAIL rx_a5_data: got %h want a5", data_rx);
        end
        nvec++;
        if ({data_rx_seq, data_rx_valid} !== 2'b11) begin
            nerr++; $display("FAIL rx_a5_seq_valid: got %b want 11", {data_rx_seq, data_rx_valid});
        end
        // Stop bit is sampled at frame cycle 155; presentation must follow within 2.
        nvec++;
        if ((tog_idx >= 155 && tog_idx <= 157) !== 1'b1) begin
            nerr++; $display("FAIL rx_a5_latency: got cycle %0d want 155..157", tog_idx);
        end
        nvec++;
        if (fe_cnt !== 0) begin
            nerr++; $display("FAIL rx_a5_no_ferr: got %0d want 0", fe_cnt);
        end
        idle(20);
        nvec++;
        if ({data_rx_valid, data_rx} !== {1'b1, 8'hA5}) begin
            nerr++; $display("FAIL rx_a5_hold: got %b/%h want 1/a5", data_rx_valid, data_rx);
        end
        data_rx_ack = 1'b1;
        @(negedge clk);
        nvec++;
        if ({data_rx_valid, data_rx_seq} !== 2'b01) begin
            nerr++; $display("FAIL rx_a5_ack: got %b want 01", {data_rx_valid, data_rx_seq});
        end
        idle(16);
    endtask

    task automatic test_frame_err();
        uart_send(8'h12, 1'b0);
        nvec++;
        if (fe_cnt !== 1) begin
            nerr++; $display("FAIL ferr_pulse_len: got %0d want 1", fe_cnt);
        end
        nvec++;
        if ({tog_idx != 0, data_rx_seq, data_rx_valid} !== 3'b010) begin
            nerr++; $display("FAIL ferr_no_byte: got %b want 010",
                             {tog_idx != 0, data_rx_seq, data_rx_valid});
        end
        idle(32);
        uart_send(8'h55, 1'b1);
        nvec++;
        if ({data_rx, data_rx_seq, data_rx_valid} !== {8'h55, 2'b01}) begin
            nerr++; $display("FAIL ferr_then_55: got %h/%b%b want 55/01",
                             data_rx, data_rx_seq, data_rx_valid);
        end
        nvec++;
        if (fe_cnt !== 0) begin
            nerr++; $display("FAIL ferr_55_clean: got %0d want 0", fe_cnt);
        end
        data_rx_ack = 1'b0;
        @(negedge clk);
        nvec++;
        if (data_rx_valid !== 1'b0) begin
            nerr++; $display("FAIL ferr_55_ack: got %b want 0", data_rx_valid);
        end
        idle(16);
    endtask

    task automatic test_glitch();
        int  fe;
        logic seq0;
        fe   = 0;
        seq0 = data_rx_seq;
        rxd  = 1'b0;
        idle(5);
        rxd = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_err === 1'b1) fe++;
        end
        nvec++;
        if (fe !== 0) begin
            nerr++; $display("FAIL glitch_ferr: got %0d want 0", fe);
        end
        nvec++;
        if ({data_rx_seq, data_rx_valid} !== {seq0, 1'b0}) begin
            nerr++; $display("FAIL glitch_no_byte: got %b want %b0",
                             {data_rx_seq, data_rx_valid}, seq0);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        for (int k = 1; k <= 6; k++) begin
            exp = 8'(17 * k);
            uart_send(exp, 1'b1);
            nvec++;
            if (ov_cnt !== ((k > Retain) ? 1 : 0)) begin
                nerr++; $display("FAIL overrun_byte%0d: got %0d pulses want %0d",
                                 k, ov_cnt, (k > Retain) ? 1 : 0);
            end
            idle(16);
        end
        for (int k = 1; k <= Retain; k++) begin
            exp = 8'(17 * k);
            nvec++;
            if ({data_rx_valid, data_rx} !== {1'b1, exp}) begin
                nerr++; $display("FAIL drain_byte%0d: got %b/%h want 1/%h",
                                 k, data_rx_valid, data_rx, exp);
            end
            data_rx_ack = data_rx_seq;
            idle(2);
        end
        nvec++;
        if (data_rx_valid !== 1'b0) begin
            nerr++; $display("FAIL drain_empty: got %b want 0", data_rx_valid);
        end
    endtask

    // 0x3C frame, a mid-frame request (0xFF) that must wait, then reset during its start bit.
    task automatic test_tx_and_reset();
        logic [9:0] fr;
        logic       bad;
        fr          = {1'b1, 8'h3C, 1'b0};
        data_tx     = 8'h3C;
        data_tx_seq = ~data_tx_seq;
        for (int j = 0; j < 10; j++) begin
            bad = 1'b0;
            for (int k = 0; k < int'(Cpb); k++) begin
                @(negedge clk);
                if (j == 0 && k == 0) begin
                    nvec++;
                    if (data_tx_ack !== data_tx_seq) begin
                        nerr++; $display("FAIL tx_ack_1cyc: got %b want %b", data_tx_ack, data_tx_seq);
                    end
                end
                if (txd !== fr[j]) bad = 1'b1;
                if (j == 4 && k == 0) begin
                    data_tx     = 8'hFF;
                    data_tx_seq = ~data_tx_seq;
                end
            end
            nvec++;
            if (bad !== 1'b0) begin
                nerr++; $display("FAIL tx_3c_bit%0d: txd deviated want %b for 16 cycles", j, fr[j]);
            end
        end
        nvec++;
        if (data_tx_ack !== 1'b1) begin
            nerr++; $display("FAIL tx_busy_no_ack: got %b want 1", data_tx_ack);
        end
        @(negedge clk);
        nvec++;
        if ({txd, data_tx_ack} !== 2'b11) begin
            nerr++; $display("FAIL tx_idle_pass: got %b want 11", {txd, data_tx_ack});
        end
        @(negedge clk);
        nvec++;
        if ({txd, data_tx_ack} !== 2'b00) begin
            nerr++; $display("FAIL tx_b2b_start: got %b want 00", {txd, data_tx_ack});
        end
        idle(8);
        nvec++;
        if (txd !== 1'b0) begin
            nerr++; $display("FAIL tx_ff_start_bit: got %b want 0", txd);
        end
        reset       = 1'b0;
        data_tx_seq = 1'b0;
        data_rx_ack = 1'b0;
        @(negedge clk);
        nvec++;
        if ({txd, data_tx_ack, data_rx_seq, data_rx_valid} !== 4'b1000) begin
            nerr++; $display("FAIL reset_mid_tx: got %b want 1000",
                             {txd, data_tx_ack, data_rx_seq, data_rx_valid});
        end
        idle(2);
        reset = 1'b1;
        idle(40);
        nvec++;
        if ({txd, data_tx_ack} !== 2'b10) begin
            nerr++; $display("FAIL reset_tx_aborted: got %b want 10", {txd, data_tx_ack});
        end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_tx_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
